uart_rx_ctrl: RTL

Receive-side controller for the USB-CDC UART bridge. It sits between the register/command layer and the byte receiver (`uart_byte_rx`, instantiated alongside it):
- Shadows the line configuration and applies changes only between frames.
- Buffers received bytes and their parity flag in a FIFO with a ready/valid output.
- Detects silent framing failures with a per-frame watchdog.
- Signals end-of-packet after a programmable idle gap, and keeps saturating statistics.

---
 rtl/uart_rx_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the USB-CDC UART bridge.
// Shadows line configuration, buffers received bytes in a FWFT FIFO,
// watches each frame for silent framing failures, flags end-of-packet
// after an idle gap and keeps saturating statistics.
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          uart_rx,
   input  logic [15:0]                   cfg_baud_divisor,
   input  logic [3:0]                    cfg_bits,
   input  logic [1:0]                    cfg_parity,
   input  logic [1:0]                    cfg_stop,
   input  logic [7:0]                    cfg_idle_timeout,
   input  logic                          cfg_wr,
   output logic                          cfg_pending,
   output logic                          cfg_applied,
   output logic [15:0]                   rx_baud_divisor,
   output logic [3:0]                    rx_bits_cfg,
   output logic [1:0]                    rx_parity_cfg,
   output logic [1:0]                    rx_stop_cfg,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_done,
   input  logic                          rx_parity_error,
   output logic [7:0]                    m_data,
   output logic                          m_perr,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          pkt_timeout,
   input  logic                          stat_clr,
   output logic [15:0]                   stat_bytes,
   output logic [15:0]                   stat_perr,
   output logic [15:0]                   stat_ovf,
   output logic [15:0]                   stat_ferr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [15:0] div;
      logic [3:0]  bits;
      logic [1:0]  par;
      logic [1:0]  stop;
      logic [7:0]  idle;
   } cfg_t;

   localparam cfg_t CFG_RST = '{div: 16'd434, bits: 4'd8, par: 2'd0, stop: 2'd1, idle: 8'd0};

   typedef enum logic {ST_IDLE, ST_FRAME} state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

   logic          sync1_q, sync2_q, line_q;
   logic          fall, tick, apply, wd_expire;
   logic [15:0]   tick_lim;
   logic [15:0]   tick_cnt_q, tick_cnt_d;
   state_t        state_q;
   logic [4:0]    wd_q, frame_len;
   cfg_t          cfg_in, shadow_q, shadow_d, active_q, active_d;
   logic          pending_q, pending_d, applied_q, applied_d;
   logic [8:0]    mem_q [FIFO_DEPTH];
   logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
   logic          full, empty, push, pop, ovf;
   logic [15:0]   bytes_q, bytes_d, perr_q, perr_d, ovf_q, ovf_d, ferr_q, ferr_d;
   logic [7:0]    idle_cnt_q, idle_cnt_d, idle_next;
   logic          idle_hold_q, idle_hold_d, seen_q, seen_d, pkt_q, pkt_d;

   // Line is idle-high; a falling edge is seen one cycle after the 2-FF synchronizer.
   assign fall = line_q & ~sync2_q;

   // Bit tick period never drops below 16 clocks.
   assign tick_lim = (active_q.div < 16'd16) ? 16'd16 : active_q.div;
   assign tick     = !fall && (tick_cnt_q >= tick_lim - 16'd1);

   // Watchdog span: start + data + optional parity + stop + one bit of slack.
   assign frame_len = 5'd2 + {1'b0, active_q.bits} + {4'b0, |active_q.par} + {3'b0, active_q.stop};
   assign wd_expire = (state_q == ST_FRAME) && !rx_done && tick && (wd_q <= 5'd1);

   assign cfg_in = '{div: cfg_baud_divisor, bits: cfg_bits, par: cfg_parity,
                     stop: cfg_stop, idle: cfg_idle_timeout};
   assign apply  = pending_q && (state_q == ST_IDLE) && !fall && !rx_done;

   assign level = wr_ptr_q - rd_ptr_q;
   assign empty = (level == '0);
   assign full  = (level == LW'(FIFO_DEPTH));
   assign pop   = !empty && m_ready;
   assign push  = rx_done && (!full || pop);
   assign ovf   = rx_done && full && !pop;

   // Next-state for bit tick, config, FIFO pointers and statistics.
   always_comb begin
      tick_cnt_d = (fall || tick) ? 16'd0 : tick_cnt_q + 16'd1;
      shadow_d   = cfg_wr ? cfg_in : shadow_q;
      pending_d  = cfg_wr ? 1'b1 : (apply ? 1'b0 : pending_q);
      active_d   = apply ? shadow_q : active_q;
      applied_d  = apply;
      wr_ptr_d   = wr_ptr_q + LW'(push);
      rd_ptr_d   = rd_ptr_q + LW'(pop);
      bytes_d    = stat_clr ? 16'd0 : sat_inc(bytes_q, rx_done);
      perr_d     = stat_clr ? 16'd0 : sat_inc(perr_q, rx_done && rx_parity_error);
      ovf_d      = stat_clr ? 16'd0 : sat_inc(ovf_q, ovf);
      ferr_d     = stat_clr ? 16'd0 : sat_inc(ferr_q, wd_expire);
   end

   // Idle-gap timer: one end-of-packet pulse per gap, only if a byte arrived.
   always_comb begin
      idle_cnt_d  = idle_cnt_q;
      idle_hold_d = idle_hold_q;
      seen_d      = seen_q | rx_done;
      pkt_d       = 1'b0;
      idle_next   = idle_cnt_q + 8'd1;
      if (fall) begin
         idle_cnt_d  = 8'd0;
         idle_hold_d = 1'b0;
      end else if ((state_q == ST_IDLE) && sync2_q && tick && !idle_hold_q &&
                   (active_q.idle != 8'd0)) begin
         idle_cnt_d = idle_next;
         if (idle_next >= active_q.idle) begin
            idle_hold_d = 1'b1;
            if (seen_q) begin
               pkt_d  = 1'b1;
               seen_d = rx_done;
            end
         end
      end
   end

   // Frame tracker: IDLE until a start edge, FRAME until rx_done or watchdog expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wd_q    <= 5'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  state_q <= ST_FRAME;
                  wd_q    <= frame_len;
               end
            end
            ST_FRAME: begin
               if (rx_done || wd_expire) state_q <= ST_IDLE;
               else if (tick)            wd_q    <= wd_q - 5'd1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Control and counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         line_q      <= 1'b1;
         tick_cnt_q  <= 16'd0;
         shadow_q    <= CFG_RST;
         active_q    <= CFG_RST;
         pending_q   <= 1'b0;
         applied_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         bytes_q     <= 16'd0;
         perr_q      <= 16'd0;
         ovf_q       <= 16'd0;
         ferr_q      <= 16'd0;
         idle_cnt_q  <= 8'd0;
         idle_hold_q <= 1'b0;
         seen_q      <= 1'b0;
         pkt_q       <= 1'b0;
      end else begin
         sync1_q     <= uart_rx;
         sync2_q     <= sync1_q;
         line_q      <= sync2_q;
         tick_cnt_q  <= tick_cnt_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         applied_q   <= applied_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         bytes_q     <= bytes_d;
         perr_q      <= perr_d;
         ovf_q       <= ovf_d;
         ferr_q      <= ferr_d;
         idle_cnt_q  <= idle_cnt_d;
         idle_hold_q <= idle_hold_d;
         seen_q      <= seen_d;
         pkt_q       <= pkt_d;
      end
   end

   // FIFO storage holds {perr, data}; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {rx_parity_error, rx_data};
   end

   assign cfg_pending     = pending_q;
   assign cfg_applied     = applied_q;
   assign rx_baud_divisor = active_q.div;
   assign rx_bits_cfg     = active_q.bits;
   assign rx_parity_cfg   = active_q.par;
   assign rx_stop_cfg     = active_q.stop;
   assign m_data          = mem_q[rd_ptr_q[AW-1:0]][7:0];
   assign m_perr          = mem_q[rd_ptr_q[AW-1:0]][8];
   assign m_valid         = !empty;
   assign fifo_level      = level;
   assign pkt_timeout     = pkt_q;
   assign stat_bytes      = bytes_q;
   assign stat_perr       = perr_q;
   assign stat_ovf        = ovf_q;
   assign stat_ferr       = ferr_q;

endmodule
